// File: rtl/fifo_fwft_param_if.sv
// Handshake and status bundle for fifo_fwft_param.
// The master drives requests, and the slave (the FIFO) drives data and status.
interface fifo_fwft_param_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) ();
   logic                     en;
   logic [WIDTH-1:0]         din;
   logic                     done;
   logic                     flush;
   logic                     clr_err;
   logic [WIDTH-1:0]         dout;
   logic [$clog2(DEPTH):0]   count;
   logic                     empty;
   logic                     full;
   logic                     almost_empty;
   logic                     almost_full;
   logic                     overflow;
   logic                     underflow;

   modport master (
      output en, din, done, flush, clr_err,
      input  dout, count, empty, full, almost_empty, almost_full, overflow, underflow
   );

   modport slave (
      input  en, din, done, flush, clr_err,
      output dout, count, empty, full, almost_empty, almost_full, overflow, underflow
   );
endinterface

// File: rtl/fifo_fwft_param.sv
// First-word-fall-through synchronous FIFO with occupancy flags and sticky error flags.
// Memory is never cleared; the pointers and the count alone define which entries are valid.
module fifo_fwft_param #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 8,
   parameter int AFULL_TH  = DEPTH - 2,
   parameter int AEMPTY_TH = 1
) (
   input logic              clk,
   input logic              rst_n,
   fifo_fwft_param_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
   localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wptr_r;
   logic [AW-1:0]    rptr_r;
   logic [CW-1:0]    count_r;
   logic             overflow_r;
   logic             underflow_r;
   logic             empty_s;
   logic             full_s;
   logic             do_read_s;
   logic             do_write_s;
   logic             mem_we_s;
   logic             ovf_set_s;
   logic             udf_set_s;

   // A full FIFO still accepts a write when a read frees a slot in the same cycle.
   always_comb begin
      empty_s    = (count_r == {CW{1'b0}});
      full_s     = (count_r == DEPTH_C);
      do_read_s  = bus.done && !empty_s;
      do_write_s = bus.en && (!full_s || bus.done);
      mem_we_s   = do_write_s && !bus.flush && rst_n;
      ovf_set_s  = bus.en && full_s && !bus.done && !bus.flush;
      udf_set_s  = bus.done && empty_s && !bus.en && !bus.flush;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_r  <= {AW{1'b0}};
         rptr_r  <= {AW{1'b0}};
         count_r <= {CW{1'b0}};
      end else if (bus.flush) begin
         wptr_r  <= {AW{1'b0}};
         rptr_r  <= {AW{1'b0}};
         count_r <= {CW{1'b0}};
      end else begin
         if (do_write_s) begin
            wptr_r <= wptr_r + PTR_ONE;
         end
         if (do_read_s) begin
            rptr_r <= rptr_r + PTR_ONE;
         end
         case ({do_write_s, do_read_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Sticky errors: a fresh error in the clearing cycle wins over clr_err.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         overflow_r  <= ovf_set_s || (overflow_r && !bus.clr_err);
         underflow_r <= udf_set_s || (underflow_r && !bus.clr_err);
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_r[wptr_r] <= bus.din;
      end
   end

   assign bus.dout         = empty_s ? {WIDTH{1'b0}} : mem_r[rptr_r];
   assign bus.count        = count_r;
   assign bus.empty        = empty_s;
   assign bus.full         = full_s;
   assign bus.almost_empty = (count_r <= AEMPTY_C);
   assign bus.almost_full  = (count_r >= AFULL_C);
   assign bus.overflow     = overflow_r;
   assign bus.underflow    = underflow_r;
endmodule
